// File: rtl/emi_wbuf_if.sv
// EMI request/response bundle shared by the cache-side and system-side ports.
// Handshake: the master raises req with address/wdata/size/RnW/bws stable and
// holds them until the slave returns a one-cycle valid pulse (with rdata for
// reads); req then drops for at least one cycle before the next request.
interface emi_wbuf_if;
  logic [31:0] address;
  logic [63:0] wdata;
  logic [1:0]  size;
  logic        RnW;
  logic [7:0]  bws;
  logic        req;
  logic [63:0] rdata;
  logic        valid;

  modport master (
    output address, wdata, size, RnW, bws, req,
    input  rdata, valid
  );

  modport slave (
    input  address, wdata, size, RnW, bws, req,
    output rdata, valid
  );
endinterface

// File: rtl/emi_wbuf.sv
// Posted-write buffer between the D-cache EMI and the system EMI.
// Writes are acknowledged once captured in a small FIFO and drained in order;
// reads wait until the FIFO is empty and no write is in flight, then pass through.
module emi_wbuf #(
  parameter int DEPTH      = 4,
  parameter int LOG2_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  emi_wbuf_if.slave         u,
  emi_wbuf_if.master        d,
  output logic              wb_empty,
  output logic              pctr_wbuf_full,
  output logic [1:0]        dbg_u_state,
  output logic [1:0]        dbg_d_state
);

  typedef enum logic [1:0] {U_IDLE, U_ACK, U_RD, U_REST} u_state_t;
  typedef enum logic [1:0] {D_IDLE, D_WR, D_RD} d_state_t;

  localparam logic [LOG2_DEPTH:0] FULL_COUNT = (LOG2_DEPTH+1)'(DEPTH);

  // FIFO storage; contents need no reset because the pointers and count do
  logic [31:0] fifo_addr  [DEPTH];
  logic [63:0] fifo_wdata [DEPTH];
  logic [1:0]  fifo_size  [DEPTH];
  logic [7:0]  fifo_bws   [DEPTH];

  logic [LOG2_DEPTH-1:0] wr_ptr;
  logic [LOG2_DEPTH-1:0] rd_ptr;
  logic [LOG2_DEPTH:0]   count;

  u_state_t u_state;
  d_state_t d_state;

  logic        u_valid_q;
  logic        d_req_q;
  logic [31:0] d_address_q;
  logic [63:0] d_wdata_q;
  logic [1:0]  d_size_q;
  logic        d_rnw_q;
  logic [7:0]  d_bws_q;

  logic push;
  logic pop;
  logic rd_start;
  logic wr_refused;

  // Request decode; fullness is judged on count before any same-cycle pop
  always_comb begin
    push       = (u_state == U_IDLE) && u.req && !u.RnW && (count < FULL_COUNT);
    wr_refused = (u_state == U_IDLE) && u.req && !u.RnW && (count == FULL_COUNT);
    rd_start   = (u_state == U_IDLE) && u.req && u.RnW && (count == '0) &&
                 (d_state == D_IDLE);
    pop        = (d_state == D_WR) && d.valid;
  end

  // Capture accepted writes at the tail
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr]  <= u.address;
      fifo_wdata[wr_ptr] <= u.wdata;
      fifo_size[wr_ptr]  <= u.size;
      fifo_bws[wr_ptr]   <= u.bws;
    end
  end

  // Pointer and occupancy bookkeeping; push and pop together leave count alone
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Upstream FSM: ack writes after capture, park on forwarded reads
  always_ff @(posedge clk) begin
    if (!reset) begin
      u_state        <= U_IDLE;
      u_valid_q      <= 1'b0;
      pctr_wbuf_full <= 1'b0;
    end else begin
      pctr_wbuf_full <= wr_refused;
      u_valid_q      <= 1'b0;
      case (u_state)
        U_IDLE: begin
          if (push) begin
            u_state   <= U_ACK;
            u_valid_q <= 1'b1;
          end else if (rd_start) begin
            u_state <= U_RD;
          end
        end
        U_ACK:   u_state <= U_REST;
        U_RD:    if (d.valid) u_state <= U_REST;
        U_REST:  u_state <= U_IDLE;
        default: u_state <= U_IDLE;
      endcase
    end
  end

  // Downstream FSM: drain the head entry or issue the forwarded read
  always_ff @(posedge clk) begin
    if (!reset) begin
      d_state     <= D_IDLE;
      d_req_q     <= 1'b0;
      d_address_q <= '0;
      d_wdata_q   <= '0;
      d_size_q    <= '0;
      d_rnw_q     <= 1'b0;
      d_bws_q     <= '0;
    end else begin
      case (d_state)
        D_IDLE: begin
          if (rd_start) begin
            d_state     <= D_RD;
            d_req_q     <= 1'b1;
            d_address_q <= u.address;
            d_size_q    <= u.size;
            d_bws_q     <= u.bws;
            d_rnw_q     <= 1'b1;
          end else if (count != '0) begin
            d_state     <= D_WR;
            d_req_q     <= 1'b1;
            d_address_q <= fifo_addr[rd_ptr];
            d_wdata_q   <= fifo_wdata[rd_ptr];
            d_size_q    <= fifo_size[rd_ptr];
            d_bws_q     <= fifo_bws[rd_ptr];
            d_rnw_q     <= 1'b0;
          end
        end
        D_WR, D_RD: begin
          if (d.valid) begin
            d_state <= D_IDLE;
            d_req_q <= 1'b0;
          end
        end
        default: d_state <= D_IDLE;
      endcase
    end
  end

  // Read completion passes straight through; write acks come from the register
  always_comb begin
    u.valid = (u_state == U_RD) ? d.valid : u_valid_q;
    u.rdata = (u_state == U_RD) ? d.rdata : '0;
  end

  assign d.req     = d_req_q;
  assign d.address = d_address_q;
  assign d.wdata   = d_wdata_q;
  assign d.size    = d_size_q;
  assign d.RnW     = d_rnw_q;
  assign d.bws     = d_bws_q;

  assign wb_empty    = (count == '0) && (d_state != D_WR);
  assign dbg_u_state = u_state;
  assign dbg_d_state = d_state;

endmodule

// File: tb/tb_emi_wbuf.sv
// Bench for emi_wbuf: upstream driver tasks, a downstream responder with
// programmable latency/stall, and an in-order scoreboard of downstream requests.
`timescale 1ns/1ps
module tb_emi_wbuf;

  localparam int W = 107;  // {RnW, size, bws, address, wdata}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  emi_wbuf_if u_bus();
  emi_wbuf_if d_bus();
  logic       wb_empty;
  logic       pctr_wbuf_full;
  logic [1:0] dbg_u_state;
  logic [1:0] dbg_d_state;

  emi_wbuf #(.DEPTH(4), .LOG2_DEPTH(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .u              (u_bus),
    .d              (d_bus),
    .wb_empty       (wb_empty),
    .pctr_wbuf_full (pctr_wbuf_full),
    .dbg_u_state    (dbg_u_state),
    .dbg_d_state    (dbg_d_state)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] pack(input logic rnw, input logic [1:0] size,
                                        input logic [7:0] bws, input logic [31:0] addr,
                                        input logic [63:0] wdata);
    return {rnw, size, bws, addr, wdata};
  endfunction

  // ---------------- downstream responder ----------------
  bit          stall = 1'b0;
  int          d_lat = 1;
  logic [63:0] rd_val = '0;
  bit          busy = 1'b0;
  int          cnt = 0;
  int          dreq_cyc = 0;
  int          dv_cyc = 0;

  always @(posedge clk) begin : responder
    logic [W-1:0] got;
    logic [W-1:0] exp;
    #1;
    if (!reset) begin
      d_bus.valid = 1'b0;
      busy = 1'b0;
    end else if (d_bus.valid) begin
      d_bus.valid = 1'b0;
      busy = 1'b0;
    end else if (!busy && d_bus.req) begin
      busy = 1'b1;
      cnt = 1;
      dreq_cyc = cyc;
      got = pack(d_bus.RnW, d_bus.size, d_bus.bws, d_bus.address, d_bus.wdata);
      if (exp_q.size() == 0) begin
        check("d_unexpected", 1, 0);
      end else begin
        exp = exp_q.pop_front();
        if (exp[W-1]) got[63:0] = '0;
        check(exp[W-1] ? "d_read_fields" : "d_write_fields", got, exp);
      end
    end else if (busy) begin
      cnt++;
      check("d_req_hold", d_bus.req, 1);
    end
    if (reset && busy && !d_bus.valid && !stall && cnt >= d_lat) begin
      d_bus.valid = 1'b1;
      d_bus.rdata = rd_val;
      dv_cyc = cyc;
    end
  end

  // u_valid is a single-cycle pulse
  logic prev_uv = 1'b0;
  always @(negedge clk) begin
    if (reset && u_bus.valid) check("u_valid_b2b", prev_uv, 0);
    prev_uv = u_bus.valid;
  end

  // ---------------- driver tasks ----------------
  task automatic up_req(input logic rnw, input logic [31:0] addr, input logic [63:0] wdata,
                        input logic [1:0] size, input logic [7:0] bws,
                        output int start_cyc, output int done_cyc, output logic [63:0] rdata);
    bit done;
    int n;
    @(posedge clk);
    #2;
    u_bus.RnW     = rnw;
    u_bus.address = addr;
    u_bus.wdata   = wdata;
    u_bus.size    = size;
    u_bus.bws     = bws;
    u_bus.req     = 1'b1;
    start_cyc     = cyc;
    exp_q.push_back(pack(rnw, size, bws, addr, rnw ? 64'h0 : wdata));
    done = 1'b0;
    n = 0;
    done_cyc = 0;
    rdata = '0;
    while (!done) begin
      @(negedge clk);
      n++;
      if (u_bus.valid) begin
        done = 1'b1;
        done_cyc = cyc;
        rdata = u_bus.rdata;
      end else if (n > 300) begin
        check("u_timeout", 1, 0);
        done = 1'b1;
      end
    end
    @(posedge clk);
    #2;
    u_bus.req = 1'b0;
  endtask

  task automatic wait_dvalid(output int at_cyc);
    bit done;
    int n;
    done = 1'b0;
    n = 0;
    at_cyc = 0;
    while (!done) begin
      @(negedge clk);
      n++;
      if (d_bus.valid) begin
        done = 1'b1;
        at_cyc = cyc;
      end else if (n > 300) begin
        check("d_valid_timeout", 1, 0);
        done = 1'b1;
      end
    end
  endtask

  task automatic wait_drain();
    bit done;
    int n;
    done = 1'b0;
    n = 0;
    while (!done) begin
      @(negedge clk);
      n++;
      if (wb_empty && !busy && exp_q.size() == 0) done = 1'b1;
      else if (n > 300) begin
        check("drain_timeout", 1, 0);
        done = 1'b1;
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_u_valid"},   u_bus.valid,    0);
    check({tag, "_u_rdata"},   u_bus.rdata,    0);
    check({tag, "_d_req"},     d_bus.req,      0);
    check({tag, "_d_address"}, d_bus.address,  0);
    check({tag, "_d_wdata"},   d_bus.wdata,    0);
    check({tag, "_d_size"},    d_bus.size,     0);
    check({tag, "_d_RnW"},     d_bus.RnW,      0);
    check({tag, "_d_bws"},     d_bus.bws,      0);
    check({tag, "_wb_empty"},  wb_empty,       1);
    check({tag, "_pctr"},      pctr_wbuf_full, 0);
  endtask

  // ---------------- stimulus ----------------
  int          s;
  int          dn;
  int          dv;
  int          rel;
  logic [63:0] r;

  initial begin
    u_bus.req = 1'b0; u_bus.RnW = 1'b0; u_bus.address = '0;
    u_bus.wdata = '0; u_bus.size = '0; u_bus.bws = '0;
    d_bus.valid = 1'b0; d_bus.rdata = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("init");
    @(posedge clk);
    #2 reset = 1'b1;

    // Single write: ack at N+1, d_req at N+2, wb_empty back the cycle after d_valid
    d_lat = 3;
    up_req(1'b0, 32'hC000_0010, 64'h1122_3344_5566_7788, 2'b11, 8'hFF, s, dn, r);
    check("wr_ack_lat", dn, s + 1);
    wait_dvalid(dv);
    check("wr_dreq_lat", dreq_cyc, s + 2);
    check("wr_dvalid_cyc", dv, s + 4);
    check("wb_empty_at_dvalid", wb_empty, 0);
    @(negedge clk);
    check("wb_empty_after", wb_empty, 1);

    // Stalled downstream: 4 writes fill the buffer, the 5th is refused
    stall = 1'b1;
    d_lat = 1;
    for (int i = 0; i < 4; i++) begin
      up_req(1'b0, 32'h0000_0100 + 32'(i * 8), {$urandom, $urandom}, 2'b11, 8'hFF, s, dn, r);
      check("fill_ack_lat", dn, s + 1);
    end
    fork
      up_req(1'b0, 32'h0000_0120, 64'h5555_AAAA_5555_AAAA, 2'b10, 8'h0F, s, dn, r);
      begin
        @(posedge clk);
        @(negedge clk);
        repeat (5) begin
          @(negedge clk);
          check("pctr_full", pctr_wbuf_full, 1);
        end
        @(posedge clk);
        #2 stall = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("release_dvalid", d_bus.valid, 1);
        rel = cyc;
      end
    join
    check("full_accept_after_pop", dn, rel + 2);
    @(negedge clk);
    check("pctr_idle", pctr_wbuf_full, 0);
    wait_drain();

    // Three writes then a read: the read waits for the writes to drain in order
    d_lat = 4;
    rd_val = 64'hDEAD_BEEF_CAFE_F00D;
    for (int i = 0; i < 3; i++)
      up_req(1'b0, 32'h0000_0200 + 32'(i * 8), {$urandom, $urandom}, 2'b11, 8'hFF, s, dn, r);
    up_req(1'b1, 32'h0000_1000, 64'h0, 2'b11, 8'h00, s, dn, r);
    check("rd_rdata", r, 64'hDEAD_BEEF_CAFE_F00D);
    check("rd_uvalid_cyc", dn, dv_cyc);
    wait_drain();

    // Read with the buffer empty, downstream latency 7
    d_lat = 7;
    rd_val = {$urandom, $urandom};
    up_req(1'b1, 32'h2000_0040, 64'h0, 2'b10, 8'h00, s, dn, r);
    check("erd_dreq_lat", dreq_cyc, s + 1);
    check("erd_dvalid_cyc", dv_cyc, dreq_cyc + 6);
    check("erd_uvalid_cyc", dn, dv_cyc);
    check("erd_rdata", r, rd_val);
    wait_drain();

    // Pointer wrap: 10 writes drained as they arrive
    d_lat = 1;
    for (int i = 0; i < 10; i++) begin
      up_req(1'b0, 32'h3000_0000 + 32'(i * 4), {$urandom, $urandom}, 2'(i), 8'(1 << (i % 8)), s, dn, r);
      check("wrap_ack_lat", dn, s + 1);
    end
    wait_drain();

    // Reset while a write is in flight with 3 entries buffered
    stall = 1'b1;
    for (int i = 0; i < 3; i++)
      up_req(1'b0, 32'h4000_0000 + 32'(i * 8), {$urandom, $urandom}, 2'b11, 8'hFF, s, dn, r);
    @(posedge clk);
    #2 reset = 1'b0;
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("mid_reset");
    @(posedge clk);
    #2 reset = 1'b1;
    stall = 1'b0;
    repeat (20) @(negedge clk);
    check("post_reset_empty", wb_empty, 1);
    check("post_reset_no_req", d_bus.req, 0);
    up_req(1'b0, 32'h5000_0008, 64'h0123_4567_89AB_CDEF, 2'b11, 8'hF0, s, dn, r);
    check("post_reset_ack_lat", dn, s + 1);
    wait_drain();

    check("sb_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: bench did not finish, %0d miscompares so far", miscompares);
    $fatal(1);
  end

endmodule

// File: doc/emi_wbuf.md
# emi_wbuf

Posted-write buffer between the D-side cache's external memory interface (EMI) and the system EMI port. Cache writebacks and uncacheable stores are acknowledged upstream as soon as they are captured in a small FIFO, then drained to the downstream EMI in order. Reads are held until the buffer is empty, then forwarded unchanged. This preserves program order without address comparison, and removes write latency from the MEM stage's critical stalls.

## Interface
- `DEPTH`, default 4: number of buffered writes; must be a power of 2, at least 2.
- `LOG2_DEPTH`, default 2: log2(`DEPTH`).
- `clk` in 1: the block's single clock.
- `reset` in 1: synchronous, active-low reset.
- `u_address` in 32: upstream (cache) request address.
- `u_wdata` in 64: upstream write data.
- `u_size` in 2: upstream access size.
- `u_RnW` in 1: 1 = read, 0 = write.
- `u_bws` in 8: upstream byte-write strobes.
- `u_req` in 1: upstream request; held with stable fields until `u_valid`.
- `u_rdata` out 64: read data returned upstream.
- `u_valid` out 1: one-cycle completion pulse to upstream.
- `d_address` out 32: downstream request address.
- `d_wdata` out 64: downstream write data.
- `d_size` out 2: downstream access size.
- `d_RnW` out 1: downstream read/write.
- `d_bws` out 8: downstream byte-write strobes.
- `d_req` out 1: downstream request; same protocol as `u_req`.
- `d_rdata` in 64: downstream read data.
- `d_valid` in 1: one-cycle downstream completion pulse.
- `wb_empty` out 1: buffer empty and no downstream write in flight; consumed by sync/eieio sequencing.
- `pctr_wbuf_full` out 1: one-cycle pulse for each cycle a write is refused because the buffer is full.

## Operation
- FIFO storage per entry: address[31:0], wdata[63:0], size[1:0], bws[7:0].
- FIFO pointers are `LOG2_DEPTH` bits wide and wrap naturally. `count` is `LOG2_DEPTH`+1 bits, range 0..`DEPTH`.
- Upstream FSM states:
  - U_IDLE: samples `u_req`.
  - U_ACK: drives `u_valid`=1.
  - U_RD: waits for the forwarded read.
  - U_REST: ignores `u_req`.
- U_IDLE with `u_req` and `u_RnW`=0:
  - If `count` < `DEPTH`: push the entry and go to U_ACK.
  - Otherwise: stay in U_IDLE and pulse `pctr_wbuf_full`.
- Fullness is judged on `count` before any same-cycle pop. A write arriving while the buffer is full waits at least one cycle, even if a pop occurs in that cycle.
- U_IDLE with `u_req` and `u_RnW`=1:
  - If `count`==0 and the downstream FSM is in D_IDLE: go to U_RD and start the forwarded read.
  - Otherwise: stay in U_IDLE.
- U_ACK always goes to U_REST. U_REST always goes to U_IDLE.
- U_RD: `u_valid` = `d_valid` and `u_rdata` = `d_rdata`, both combinational. On `d_valid`, go to U_REST.
- Downstream FSM states: D_IDLE, D_WR, D_RD.
- D_IDLE:
  - If U_IDLE is starting a read: go to D_RD.
  - Else if `count` > 0: load the head entry into the `d_*` output registers (`d_RnW`=0) and go to D_WR.
- D_WR: `d_req`=1. On `d_valid`: pop the head, go to D_IDLE, and drop `d_req`.
- D_RD: `d_req`=1. `d_address`, `d_size` and `d_bws` are registered copies of the upstream fields captured at the start of the read; `d_RnW`=1. On `d_valid`, go to D_IDLE.
- Between downstream transactions, `d_req` is low for at least one cycle.
- Reads never overtake writes: a read is not issued while any write is buffered or in flight.
- `wb_empty` = (`count`==0) && (downstream FSM not in D_WR).
- A simultaneous push and pop leaves `count` unchanged.

## Timing
- Reset values: `u_valid`=0, `u_rdata`=0, `d_req`=0, all `d_*` fields 0, `wb_empty`=1, `pctr_wbuf_full`=0. Both FSMs are in their IDLE states and `count`=0.
- Reset mid-operation discards all buffered writes and abandons any downstream transaction. It does so in the same edge, without waiting for `d_valid`.
- Write accepted in cycle N:
  - `u_valid`=1 in N+1.
  - `u_req` is ignored in N+2.
  - The next request is sampled from N+3.
- Write drain with the buffer previously empty: `count`=1 from N+1; `d_req`=1 from N+2 until the cycle of `d_valid`.
- Forwarded read sampled in cycle N with the buffer empty:
  - `d_req`=1 from N+1.
  - `d_valid` in cycle M gives `u_valid`/`u_rdata` in M.
  - `u_req` is ignored in M+1.
- Back-to-back writes are accepted every 3 cycles upstream. Drain throughput is bounded by downstream latency plus 1 idle cycle.
- `u_valid` is never high for two consecutive cycles.

## Test plan
- Single write to 0xC000_0010 (wdata 0x1122334455667788, bws 0xFF):
  - `u_valid` at N+1.
  - `d_req` at N+2 with identical fields.
  - `wb_empty` returns to 1 the cycle after `d_valid`.
- Downstream stalled (`d_valid` held low), 5 writes issued:
  - First 4 acknowledged.
  - 5th holds with `pctr_wbuf_full` pulsing each cycle.
  - Releasing one `d_valid` lets the 5th be accepted no earlier than the following cycle.
- 3 writes, then a read of 0x0000_1000:
  - The read does not appear on `d_req` until all 3 writes have drained in order.
  - `u_rdata` equals the returned `d_rdata` 0xDEADBEEFCAFEF00D in the `d_valid` cycle.
- Read with the buffer empty: `d_req` at N+1 and `d_RnW`=1; a `d_valid` delay of 7 cycles gives `u_valid` exactly in that cycle.
- Pointer wrap: 10 writes, each drained immediately; the downstream address sequence matches the issue order across 2+ wraps, with `count` never exceeding 4.
- `reset` driven low during D_WR with 3 entries buffered, then released: all outputs return to reset values, `wb_empty`=1, and no stale entry is later issued.
